spike_rate_encoder: RTL and testbench

- Rate-codes a vector of signed activation values into per-timestep binary spike vectors using integrate-and-fire with reset-by-subtraction.
- Sits at the input edge of the spiking array. It is the encoder counterpart of the threshold/accumulator activation path: an accumulated count over T steps reproduces floor(T*value/threshold).
- Emits one spike vector per timestep over a valid/ready handshake, with frame markers so downstream spike accumulators can be cleared.

---
 rtl/spike_encoder_pkg.sv | 39 +++
 rtl/spike_rate_encoder_channel.sv | 77 +++++++
 rtl/spike_rate_encoder.sv | 127 ++++++++++++
 tb/tb_spike_rate_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spike_encoder_pkg.sv
// Shared definitions for the spike rate encoder: FSM state encoding,
// residual width helper and the value clamp used when a frame is latched.
package spike_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

    // Residual needs one bit of headroom above a value so r + v never wraps.
    localparam int RES_EXTRA_BITS = 1;

    // Clamp arithmetic runs at a fixed width; DATA_WIDTH must not exceed it.
    localparam int CLAMP_W = 32;

    function automatic int res_width(input int data_width);
        return data_width + RES_EXTRA_BITS;
    endfunction

    // Clamp value into [0, thr]; a non-positive threshold collapses to 0.
    function automatic logic signed [CLAMP_W-1:0] clamp_to_thr(
        input logic signed [CLAMP_W-1:0] value,
        input logic signed [CLAMP_W-1:0] thr
    );
        logic signed [CLAMP_W-1:0] result;
        if (thr <= 32'sd0) begin
            result = 32'sd0;
        end else if (value < 32'sd0) begin
            result = 32'sd0;
        end else if (value > thr) begin
            result = thr;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/spike_rate_encoder_channel.sv
// One integrate-and-fire channel: latches a clamped value, accumulates it into
// a residual each step and fires with reset-by-subtraction.
// Optional macro SPIKE_RATE_ENCODER_ROUND_EN starts the residual at thr>>>1.
module encoder_channel
    import spike_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  logic                         i_advance,
    input  logic signed [DATA_WIDTH-1:0] i_value,
    input  logic signed [DATA_WIDTH-1:0] i_load_thr,
    input  logic signed [DATA_WIDTH-1:0] i_thr,
    output logic                         o_fire
);

    localparam int RW = res_width(DATA_WIDTH);

    logic signed [DATA_WIDTH-1:0] r_value;
    logic signed [RW-1:0]         r_resid;

    logic signed [CLAMP_W-1:0]    w_clamped;
    logic signed [DATA_WIDTH-1:0] w_value_load;
    logic signed [RW-1:0]         w_resid_init;
    logic signed [RW-1:0]         w_thr_ext;
    logic signed [RW-1:0]         w_sum;
    logic signed [RW-1:0]         w_resid_next;
    logic                         w_thr_pos;
    logic                         w_load_thr_pos;

    always_comb begin
        w_clamped      = clamp_to_thr(CLAMP_W'(i_value), CLAMP_W'(i_load_thr));
        w_value_load   = DATA_WIDTH'(w_clamped);
        w_load_thr_pos = !i_load_thr[DATA_WIDTH-1] && (i_load_thr != {DATA_WIDTH{1'b0}});
`ifdef SPIKE_RATE_ENCODER_ROUND_EN
        if (w_load_thr_pos) begin
            w_resid_init = RW'(i_load_thr >>> 1);
        end else begin
            w_resid_init = {RW{1'b0}};
        end
`else
        w_resid_init = {RW{1'b0}};
`endif
    end

    // Step arithmetic; a non-positive threshold fires every step and pins the residual at 0.
    always_comb begin
        w_thr_pos = !i_thr[DATA_WIDTH-1] && (i_thr != {DATA_WIDTH{1'b0}});
        w_thr_ext = RW'(i_thr);
        w_sum     = r_resid + RW'(r_value);
        o_fire    = !w_thr_pos || (w_sum >= w_thr_ext);
        if (!w_thr_pos) begin
            w_resid_next = {RW{1'b0}};
        end else if (o_fire) begin
            w_resid_next = w_sum - w_thr_ext;
        end else begin
            w_resid_next = w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= {DATA_WIDTH{1'b0}};
            r_resid <= {RW{1'b0}};
        end else if (i_load) begin
            r_value <= w_value_load;
            r_resid <= w_resid_init;
        end else if (i_advance) begin
            r_resid <= w_resid_next;
        end else begin
            r_resid <= r_resid;
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes NUM_CHANNELS signed values into T per-step spike vectors over a
// valid/ready stream. Optional macro: SPIKE_RATE_ENCODER_ROUND_EN (round-to-nearest counts).
module spike_rate_encoder
    import spike_encoder_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 3,
    parameter int STEP_WIDTH   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [STEP_WIDTH-1:0]              num_steps,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] values,
    input  logic [DATA_WIDTH-1:0]              threshold,
    output logic                               busy,
    output logic                               spike_valid,
    input  logic                               spike_ready,
    output logic [NUM_CHANNELS-1:0]            spikes,
    output logic                               first_step,
    output logic                               last_step,
    output logic                               done
);

    enc_state_t              r_state;
    enc_state_t              w_state_next;
    logic [STEP_WIDTH-1:0]   r_steps;
    logic [STEP_WIDTH-1:0]   r_count;
    logic [DATA_WIDTH-1:0]   r_thr;

    logic                    w_load;
    logic                    w_handshake;
    logic                    w_last;
    logic [NUM_CHANNELS-1:0] w_fire;

    assign w_load      = (r_state == ST_IDLE) && start;
    assign w_handshake = (r_state == ST_RUN) && spike_ready;
    assign w_last      = (r_count == (r_steps - STEP_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (num_steps != {STEP_WIDTH{1'b0}}) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_handshake && w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Frame parameters are captured once; the counter only moves on an accepted vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_steps <= {STEP_WIDTH{1'b0}};
            r_count <= {STEP_WIDTH{1'b0}};
            r_thr   <= {DATA_WIDTH{1'b0}};
        end else if (w_load) begin
            r_steps <= num_steps;
            r_count <= {STEP_WIDTH{1'b0}};
            r_thr   <= threshold;
        end else if (w_handshake) begin
            r_count <= r_count + STEP_WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        encoder_channel #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_load),
            .i_advance  (w_handshake),
            .i_value    (values[c*DATA_WIDTH +: DATA_WIDTH]),
            .i_load_thr (threshold),
            .i_thr      (r_thr),
            .o_fire     (w_fire[c])
        );
    end

    always_comb begin
        busy        = 1'b0;
        spike_valid = 1'b0;
        spikes      = {NUM_CHANNELS{1'b0}};
        first_step  = 1'b0;
        last_step   = 1'b0;
        done        = 1'b0;
        if (r_state == ST_RUN) begin
            busy        = 1'b1;
            spike_valid = 1'b1;
            spikes      = w_fire;
            first_step  = (r_count == {STEP_WIDTH{1'b0}});
            last_step   = w_last;
        end else if (r_state == ST_DONE) begin
            busy        = 1'b1;
            done        = 1'b1;
        end else begin
            busy        = 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed self-checking bench for spike_rate_encoder (floor and rounding builds).
module tb_spike_rate_encoder;

`ifdef SPIKE_RATE_ENCODER_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_steps;
    logic [47:0] values;
    logic [15:0] threshold;
    logic        busy;
    logic        spike_valid;
    logic        spike_ready;
    logic [2:0]  spikes;
    logic        first_step;
    logic        last_step;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [15:0] m0, m1, m2, fm, lm;
    int          nhs;

    always #5 clk = ~clk;

    spike_rate_encoder #(
        .DATA_WIDTH   (16),
        .NUM_CHANNELS (3),
        .STEP_WIDTH   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_steps   (num_steps),
        .values      (values),
        .threshold   (threshold),
        .busy        (busy),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spikes      (spikes),
        .first_step  (first_step),
        .last_step   (last_step),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame; masks hold one bit per accepted vector (bit k = step k+1).
    task automatic run_frame(
        input  logic [7:0]         t,
        input  logic signed [15:0] thr,
        input  logic signed [15:0] v0,
        input  logic signed [15:0] v1,
        input  logic signed [15:0] v2,
        input  bit                 toggle,
        input  bit                 poke,
        output logic [15:0]        o_m0,
        output logic [15:0]        o_m1,
        output logic [15:0]        o_m2,
        output logic [15:0]        o_fm,
        output logic [15:0]        o_lm,
        output int                 o_nhs
    );
        int         cyc;
        bit         held;
        logic [5:0] held_vec;
        o_m0 = '0; o_m1 = '0; o_m2 = '0; o_fm = '0; o_lm = '0;
        o_nhs = 0;
        cyc = 0;
        held = 1'b0;
        held_vec = '0;
        @(posedge clk) #1;
        start       = 1'b1;
        num_steps   = t;
        threshold   = thr;
        values      = {v2, v1, v0};
        spike_ready = toggle ? 1'b0 : 1'b1;
        @(posedge clk) #1;
        start = poke;
        if (poke) begin
            num_steps = 8'd1;
            threshold = 16'sd1;
            values    = {16'sd7, 16'sd7, 16'sd7};
        end
        @(negedge clk);
        chk("latency_valid", {31'd0, spike_valid}, 32'd1);
        while (o_nhs < int'(t) && cyc < 200) begin
            if (held) begin
                chk("hold_stable", {26'd0, spike_valid, first_step, last_step, spikes},
                    {26'd0, 1'b1, held_vec[4:0]});
                held = 1'b0;
            end
            if (spike_valid && spike_ready) begin
                o_m0[o_nhs] = spikes[0];
                o_m1[o_nhs] = spikes[1];
                o_m2[o_nhs] = spikes[2];
                o_fm[o_nhs] = first_step;
                o_lm[o_nhs] = last_step;
                o_nhs++;
            end else if (spike_valid) begin
                held = 1'b1;
                held_vec = {1'b1, first_step, last_step, spikes};
            end
            @(posedge clk) #1;
            start = 1'b0;
            if (toggle) spike_ready = ~spike_ready;
            @(negedge clk);
            cyc++;
        end
        chk("frame_handshakes", o_nhs, {24'd0, t});
        chk("done_pulse", {29'd0, done, busy, spike_valid}, 32'b110);
        @(posedge clk) #1;
        spike_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_done", {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_steps = 8'd0; values = 48'd0;
        threshold = 16'd0; spike_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {24'd0, busy, spike_valid, spikes, first_step, last_step, done}, 32'd0);

        // Scenario 1: thr=128, T=8, values {64,128,0}, ready always high
        run_frame(8'd8, 16'sd128, 16'sd64, 16'sd128, 16'sd0, 1'b0, 1'b0, m0, m1, m2, fm, lm, nhs);
        chk("s1_ch0", m0, ROUND ? 32'h55 : 32'hAA);
        chk("s1_ch1", m1, 32'hFF);
        chk("s1_ch2", m2, 32'h00);
        chk("s1_first", fm, 32'h01);
        chk("s1_last", lm, 32'h80);

        // Scenario 2: clamping of negative and oversized values
        run_frame(8'd3, 16'sd128, 16'sd43, -16'sd5, 16'sd300, 1'b0, 1'b0, m0, m1, m2, fm, lm, nhs);
        chk("s2_ch0", m0, ROUND ? 32'b010 : 32'b100);
        chk("s2_ch1", m1, 32'b000);
        chk("s2_ch2", m2, 32'b111);
        chk("s2_last", lm, 32'b100);

        // Scenario 3: scenario 1 under alternating backpressure
        run_frame(8'd8, 16'sd128, 16'sd64, 16'sd128, 16'sd0, 1'b1, 1'b0, m0, m1, m2, fm, lm, nhs);
        chk("s3_ch0", m0, ROUND ? 32'h55 : 32'hAA);
        chk("s3_ch1", m1, 32'hFF);
        chk("s3_ch2", m2, 32'h00);
        chk("s3_first", fm, 32'h01);
        chk("s3_last", lm, 32'h80);

        // Scenario 4: value 86 with a start pulse (and input changes) during RUN
        run_frame(8'd3, 16'sd128, 16'sd86, 16'sd0, 16'sd0, 1'b0, 1'b1, m0, m1, m2, fm, lm, nhs);
        chk("s4_ch0", m0, ROUND ? 32'b101 : 32'b110);
        chk("s4_ch1", m1, 32'b000);

        // Scenario 5: negative threshold fires every channel every step
        run_frame(8'd2, -16'sd4, 16'sd5, -16'sd3, 16'sd0, 1'b0, 1'b0, m0, m1, m2, fm, lm, nhs);
        chk("s5_ch0", m0, 32'b11);
        chk("s5_ch1", m1, 32'b11);
        chk("s5_ch2", m2, 32'b11);

        // Scenario 6: T=0 goes straight to DONE
        @(posedge clk) #1;
        start = 1'b1; num_steps = 8'd0; threshold = 16'sd128;
        values = {16'sd0, 16'sd128, 16'sd64};
        @(posedge clk) #1;
        start = 1'b0;
        @(negedge clk);
        chk("t0_done_cycle", {29'd0, busy, done, spike_valid}, 32'b110);
        @(negedge clk);
        chk("t0_idle", {29'd0, busy, done, spike_valid}, 32'b000);

        // Scenario 7: reset after three handshakes, then a clean rerun
        @(posedge clk) #1;
        start = 1'b1; num_steps = 8'd8; threshold = 16'sd128;
        values = {16'sd0, 16'sd128, 16'sd64}; spike_ready = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_frame", {29'd0, busy, spike_valid, done}, 32'd0);
        @(negedge clk);
        chk("rst_no_done", {31'd0, done}, 32'd0);
        run_frame(8'd8, 16'sd128, 16'sd64, 16'sd128, 16'sd0, 1'b0, 1'b0, m0, m1, m2, fm, lm, nhs);
        chk("s7_ch0", m0, ROUND ? 32'h55 : 32'hAA);
        chk("s7_ch1", m1, 32'hFF);
        chk("s7_first", fm, 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
